// File: rtl/dh_pkg.sv
// Shared types and constants for the duck-hunt score/ammo controller.
package dh_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, GRACE, GAME_OVER} game_state_t;
  typedef logic [3:0] bcd_t;

  localparam logic [3:0] DP_NORMAL = 4'b1011;
  localparam logic [3:0] DP_OFF    = 4'b1111;

  // Two-digit BCD of a binary value 0..99, used for elaboration-time constants.
  function automatic logic [7:0] to_bcd(input int unsigned v);
    int unsigned t;
    int unsigned u;
    t = (v / 10) % 10;
    u = v % 10;
    return {t[3:0], u[3:0]};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD up/down counter with load; saturates at max_val and at 00.
module bcd2_counter
  import dh_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  input  logic       dec,
  input  logic [7:0] max_val,
  output bcd_t       tens,
  output bcd_t       units,
  output logic       is_zero
);

  bcd_t tens_q, tens_d;
  bcd_t units_q, units_d;
  logic at_max;

  assign at_max  = ({tens_q, units_q} == max_val);
  assign is_zero = (tens_q == 4'd0) && (units_q == 4'd0);
  assign tens    = tens_q;
  assign units   = units_q;

  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (load) begin
      tens_d  = load_val[7:4];
      units_d = load_val[3:0];
    end else if (inc && !dec && !at_max) begin
      if (units_q == 4'd9) begin
        units_d = 4'd0;
        tens_d  = tens_q + 4'd1;
      end else begin
        units_d = units_q + 4'd1;
      end
    end else if (dec && !inc && !is_zero) begin
      if (units_q == 4'd0) begin
        units_d = 4'd9;
        tens_d  = tens_q - 4'd1;
      end else begin
        units_d = units_q - 4'd1;
      end
    end
  end

  // Reset value is the load value, so the parent picks it per instance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tens_q  <= load_val[7:4];
      units_q <= load_val[3:0];
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assert property (@(posedge clk) disable iff (!rst) (tens_q <= 4'd9 && units_q <= 4'd9));

endmodule

// File: rtl/score_ammo_ctl.sv
// Game phase sequencer driving BCD score/ammo digits and decimal points to the 7-seg mux.
// state     | meaning
// IDLE      | scores shown, waiting for the starting shot
// PLAY      | shots consume ammo, hits score
// GRACE     | out of ammo, late hits still score for GRACE_FRAMES frames
// GAME_OVER | final score held, dp blinks, a shot returns to IDLE
module score_ammo_ctl
  import dh_pkg::*;
#(
  parameter int unsigned START_AMMO   = 15,
  parameter int unsigned GRACE_FRAMES = 2,
  parameter int unsigned BLINK_FRAMES = 32,
  parameter int unsigned SCORE_MAX    = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_frame,
  input  logic       mouse_left,
  input  logic       duck_hit,
  output logic [3:0] hex0,
  output logic [3:0] hex1,
  output logic [3:0] hex2,
  output logic [3:0] hex3,
  output logic [3:0] dp_out,
  output logic       game_active,
  output logic       game_over
);

  localparam int FW = $clog2(GRACE_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [7:0] AMMO_INIT = to_bcd(START_AMMO);
  localparam logic [7:0] SCORE_TOP = to_bcd(SCORE_MAX);

  game_state_t state_q, state_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d, frame_inc;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d, blink_inc;
  logic [3:0] dp_q, dp_d;
  logic game_active_q, game_active_d;
  logic game_over_q, game_over_d;
  logic mouse_left_q, duck_hit_q;
  logic shot, hit, blink_wrap;
  logic score_inc, ammo_dec, restart;
  bcd_t score_tens, score_units, ammo_tens, ammo_units;
  logic score_zero, ammo_zero, ammo_one;

  assign shot      = mouse_left & ~mouse_left_q;
  assign hit       = duck_hit & ~duck_hit_q;
  assign frame_inc = frame_cnt_q + FW'(1);
  assign blink_inc = blink_cnt_q + BW'(1);
  assign ammo_one  = ({ammo_tens, ammo_units} == 8'h01);
  assign score_inc = hit && (state_q == PLAY || state_q == GRACE);
  assign ammo_dec  = shot && (state_q == PLAY) && !ammo_zero;
  assign restart   = shot && (state_q == GAME_OVER);

  bcd2_counter u_score (
    .clk(clk), .rst(rst), .load(restart), .load_val(8'h00),
    .inc(score_inc), .dec(1'b0), .max_val(SCORE_TOP),
    .tens(score_tens), .units(score_units), .is_zero(score_zero)
  );

  bcd2_counter u_ammo (
    .clk(clk), .rst(rst), .load(restart), .load_val(AMMO_INIT),
    .inc(1'b0), .dec(ammo_dec), .max_val(AMMO_INIT),
    .tens(ammo_tens), .units(ammo_units), .is_zero(ammo_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      frame_cnt_q   <= '0;
      blink_cnt_q   <= '0;
      dp_q          <= DP_NORMAL;
      game_active_q <= 1'b0;
      game_over_q   <= 1'b0;
      mouse_left_q  <= 1'b0;
      duck_hit_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      dp_q          <= dp_d;
      game_active_q <= game_active_d;
      game_over_q   <= game_over_d;
      mouse_left_q  <= mouse_left;
      duck_hit_q    <= duck_hit;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_wrap  = 1'b0;
    case (state_q)
      IDLE: if (shot) state_d = PLAY;
      PLAY: begin
        if (shot && ammo_one) begin
          state_d     = GRACE;
          frame_cnt_d = '0;
        end
      end
      GRACE: begin
        if (new_frame) begin
          if (frame_inc == FW'(GRACE_FRAMES)) begin
            state_d     = GAME_OVER;
            blink_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_inc;
          end
        end
      end
      GAME_OVER: begin
        if (shot) begin
          state_d     = IDLE;
          blink_cnt_d = '0;
        end else if (new_frame) begin
          if (blink_inc == BW'(BLINK_FRAMES)) begin
            blink_cnt_d = '0;
            blink_wrap  = 1'b1;
          end else begin
            blink_cnt_d = blink_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    game_active_d = (state_d == PLAY) || (state_d == GRACE);
    game_over_d   = (state_d == GAME_OVER);
    dp_d          = DP_NORMAL;
    if (state_q == GAME_OVER && state_d == GAME_OVER) begin
      if (blink_wrap) dp_d = (dp_q == DP_NORMAL) ? DP_OFF : DP_NORMAL;
      else            dp_d = dp_q;
    end
  end

  assign hex0        = ammo_units;
  assign hex1        = ammo_tens;
  assign hex2        = score_units;
  assign hex3        = score_tens;
  assign dp_out      = dp_q;
  assign game_active = game_active_q;
  assign game_over   = game_over_q;

  // Score is only ever cleared on the way into IDLE, never accumulated there.
  assert property (@(posedge clk) disable iff (!rst) (state_q == IDLE) |-> score_zero);

endmodule

// File: tb/tb_score_ammo_ctl.sv
// Directed bench for score_ammo_ctl: vector table plus multi-cycle game sequences.
module tb_score_ammo_ctl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic new_frame = 1'b0;
  logic mouse_left = 1'b0;
  logic duck_hit = 1'b0;
  logic [3:0] hex0, hex1, hex2, hex3, dp_out;
  logic game_active, game_over;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [3:0] B = 4'b1011;
  localparam logic [3:0] F = 4'b1111;

  typedef struct {
    logic        rst_n;
    logic        ml;
    logic        dh;
    logic        nf;
    logic [15:0] hex;
    logic [3:0]  dp;
    logic        ga;
    logic        go;
  } vec_t;

  vec_t vecs[$];

  score_ammo_ctl #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .mouse_left(mouse_left),
    .duck_hit(duck_hit), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .dp_out(dp_out), .game_active(game_active), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic ml, logic dh, logic nf,
                              logic [15:0] hex, logic [3:0] dp, logic ga, logic go);
    vec_t v;
    v.rst_n = r; v.ml = ml; v.dh = dh; v.nf = nf;
    v.hex = hex; v.dp = dp; v.ga = ga; v.go = go;
    return v;
  endfunction

  task automatic tick(input logic ml, input logic dh, input logic nf);
    mouse_left = ml; duck_hit = dh; new_frame = nf;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_shot(); tick(1, 0, 0); tick(0, 0, 0); endtask
  task automatic pulse_hit();  tick(0, 1, 0); tick(0, 0, 0); endtask
  task automatic frame();      tick(0, 0, 1); tick(0, 0, 0); endtask

  // Compares {hex3,hex2,hex1,hex0, dp, game_active, game_over}.
  task automatic check(input string name, input logic [15:0] hex, input logic [3:0] dp,
                       input logic ga, input logic go);
    logic [21:0] act, exp;
    act = {hex3, hex2, hex1, hex0, dp_out, game_active, game_over};
    exp = {hex, dp, ga, go};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got hex=%h dp=%b ga=%b go=%b, want hex=%h dp=%b ga=%b go=%b",
               name, act[21:6], act[5:2], act[1], act[0], hex, dp, ga, go);
    end
  endtask

  initial begin
    vecs.push_back(mk(0, 0, 0, 0, 16'h0015, B, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0015, B, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0015, B, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0014, B, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0014, B, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0013, B, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0013, B, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0012, B, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 16'h0112, B, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0112, B, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 16'h0212, B, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0212, B, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 16'h0312, B, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0312, B, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0311, B, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0311, B, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0310, B, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0310, B, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0309, B, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0309, B, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0308, B, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0308, B, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0307, B, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0307, B, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0015, B, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0015, B, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0015, B, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0015, B, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0015, B, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0015, B, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst_n;
      tick(vecs[i].ml, vecs[i].dh, vecs[i].nf);
      check($sformatf("vec%0d", i), vecs[i].hex, vecs[i].dp, vecs[i].ga, vecs[i].go);
    end

    // Borrow 10 -> 09 and carry 09 -> 10 on the same edge.
    for (int i = 0; i < 5; i++) pulse_shot();
    check("ammo_10", 16'h0010, B, 1, 0);
    for (int i = 0; i < 9; i++) pulse_hit();
    check("score_09", 16'h0910, B, 1, 0);
    tick(1, 1, 0);
    check("simultaneous", 16'h1009, B, 1, 0);
    tick(0, 0, 0);

    // A held button is a single shot.
    for (int i = 0; i < 100; i++) tick(1, 0, 0);
    tick(0, 0, 0);
    check("held_button", 16'h1008, B, 1, 0);

    for (int i = 0; i < 7; i++) pulse_shot();
    check("ammo_01", 16'h1001, B, 1, 0);
    tick(1, 0, 0);
    check("last_shot", 16'h1000, B, 1, 0);
    tick(0, 0, 0);
    frame();
    check("grace_frame1", 16'h1000, B, 1, 0);
    pulse_hit();
    check("late_hit", 16'h1100, B, 1, 0);
    pulse_shot();
    check("grace_shot", 16'h1100, B, 1, 0);
    tick(0, 0, 1);
    check("game_over", 16'h1100, B, 0, 1);
    tick(0, 0, 0);
    pulse_hit();
    check("go_hit_ignored", 16'h1100, B, 0, 1);

    frame(); check("blink1", 16'h1100, B, 0, 1);
    frame(); check("blink2", 16'h1100, F, 0, 1);
    frame(); check("blink3", 16'h1100, F, 0, 1);
    frame(); check("blink4", 16'h1100, B, 0, 1);
    frame(); check("blink5", 16'h1100, B, 0, 1);
    frame(); check("blink6", 16'h1100, F, 0, 1);

    tick(1, 0, 0);
    check("restart", 16'h0015, B, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    check("no_autostart", 16'h0015, B, 0, 0);

    // Saturation at 99 in a fresh game.
    pulse_shot();
    check("new_game", 16'h0015, B, 1, 0);
    for (int i = 0; i < 99; i++) pulse_hit();
    check("score_99", 16'h9915, B, 1, 0);
    pulse_hit();
    check("score_sat", 16'h9915, B, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
